// File: rtl/auth_driver_mc.sv
// auth_driver_mc: round-robin authentication request driver with engine handshake, USB
// framing and link acknowledge. Define AUTH_DRV_TIMEOUT_EN to add the ack timeout/retry path.
module auth_driver_mc #(
  parameter int NUM_REQ     = 2,
  parameter int MSG_W       = 64,
  parameter int ACK_TIMEOUT = 255,
  parameter int MAX_RETRY   = 3,
  localparam int CH_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [8*NUM_REQ-1:0]     req_cmd,
  input  logic [MSG_W*NUM_REQ-1:0] req_msg,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     eng_start,
  output logic                     eng_role,
  output logic [MSG_W-1:0]         eng_msg,
  input  logic                     eng_done,
  input  logic [MSG_W-1:0]         eng_resp,
  output logic                     resp_valid,
  output logic [MSG_W-1:0]         resp_msg,
  output logic [CH_W-1:0]          resp_chan,
  input  logic                     ack_in,
  output logic                     err_valid,
  output logic [1:0]               err_code,
  output logic                     busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DISPATCH = 3'd1,
    ENGINE   = 3'd2,
    FRAME    = 3'd3,
    WAIT_ACK = 3'd4,
    RETRY    = 3'd5,
    ERROR    = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    rr_q, rr_d;
  logic [CH_W-1:0]    chan_q, chan_d;
  logic [1:0]         role_q, role_d;
  logic               usb_q, usb_d;
  logic [MSG_W-1:0]   msg_q, msg_d;

  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic               eng_start_q, eng_start_d;
  logic               eng_role_q, eng_role_d;
  logic [MSG_W-1:0]   eng_msg_q, eng_msg_d;
  logic               resp_valid_q, resp_valid_d;
  logic [MSG_W-1:0]   resp_msg_q, resp_msg_d;
  logic [CH_W-1:0]    resp_chan_q, resp_chan_d;
  logic               err_valid_q, err_valid_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               busy_q, busy_d;

`ifdef AUTH_DRV_TIMEOUT_EN
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  logic [CNT_W-1:0]   to_cnt_q, to_cnt_d;
  logic [3:0]         retry_q, retry_d;
`else
  // Ack wait is unbounded in this build; no timeout or retry counters exist.
`endif

  // Per-channel views of the flattened request buses.
  logic [1:0]       role_arr [NUM_REQ];
  logic             usb_arr  [NUM_REQ];
  logic [MSG_W-1:0] msg_arr  [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign role_arr[gi] = req_cmd[8*gi+4 +: 2];
      assign usb_arr[gi]  = req_cmd[8*gi+2];
      assign msg_arr[gi]  = req_msg[MSG_W*gi +: MSG_W];
    end
  endgenerate

  // Round-robin search: first pending channel at or after rr, wrapping past NUM_REQ-1.
  logic               gnt_found;
  logic [CH_W-1:0]    gnt_chan;
  logic [NUM_REQ-1:0] gnt_onehot;

  always_comb begin
    logic [CH_W:0]   sum;
    logic [CH_W-1:0] idx;
    gnt_found  = 1'b0;
    gnt_chan   = '0;
    gnt_onehot = '0;
    sum        = '0;
    idx        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_q} + (CH_W+1)'(k);
      if (sum >= (CH_W+1)'(NUM_REQ)) begin
        sum = sum - (CH_W+1)'(NUM_REQ);
      end
      idx = sum[CH_W-1:0];
      if (!gnt_found && req_valid[idx]) begin
        gnt_found       = 1'b1;
        gnt_chan        = idx;
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

  logic [CH_W-1:0] rr_after;
  assign rr_after = (chan_q == CH_W'(NUM_REQ - 1)) ? '0 : chan_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    chan_d       = chan_q;
    role_d       = role_q;
    usb_d        = usb_q;
    msg_d        = msg_q;
    req_ready_d  = '0;
    eng_start_d  = 1'b0;
    eng_role_d   = eng_role_q;
    eng_msg_d    = eng_msg_q;
    resp_valid_d = resp_valid_q;
    resp_msg_d   = resp_msg_q;
    resp_chan_d  = resp_chan_q;
    err_valid_d  = 1'b0;
    err_code_d   = err_code_q;
`ifdef AUTH_DRV_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    retry_d      = retry_q;
`endif

    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          state_d     = DISPATCH;
          chan_d      = gnt_chan;
          role_d      = role_arr[gnt_chan];
          usb_d       = usb_arr[gnt_chan];
          msg_d       = msg_arr[gnt_chan];
          req_ready_d = gnt_onehot;
`ifdef AUTH_DRV_TIMEOUT_EN
          to_cnt_d    = '0;
          retry_d     = '0;
`endif
        end
      end

      DISPATCH: begin
        if (role_q == 2'b01 || role_q == 2'b10) begin
          state_d     = ENGINE;
          eng_start_d = 1'b1;
          eng_role_d  = (role_q == 2'b10);
          eng_msg_d   = msg_q;
        end else begin
          state_d     = ERROR;
          err_valid_d = 1'b1;
          err_code_d  = 2'b01;
        end
      end

      ENGINE: begin
        if (eng_done) begin
          resp_msg_d  = eng_resp;
          resp_chan_d = chan_q;
          if (usb_q) begin
            state_d = FRAME;
          end else begin
            state_d      = WAIT_ACK;
            resp_valid_d = 1'b1;
          end
        end
      end

      FRAME: begin
        resp_msg_d[MSG_W-1 -: 8] = 8'h5A;
        resp_valid_d             = 1'b1;
        state_d                  = WAIT_ACK;
      end

      WAIT_ACK: begin
        if (ack_in) begin
          // Ack beats a timeout landing on the same cycle.
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          rr_d         = rr_after;
        end else begin
`ifdef AUTH_DRV_TIMEOUT_EN
          if (to_cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
            to_cnt_d     = '0;
            resp_valid_d = 1'b0;
            if (retry_q < 4'(MAX_RETRY)) begin
              state_d = RETRY;
              retry_d = retry_q + 4'd1;
            end else begin
              state_d     = ERROR;
              err_valid_d = 1'b1;
              err_code_d  = 2'b10;
            end
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
`else
          state_d = WAIT_ACK;
`endif
        end
      end

      RETRY: begin
        resp_valid_d = 1'b1;
        state_d      = WAIT_ACK;
      end

      ERROR: begin
        rr_d    = rr_after;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      chan_q       <= '0;
      role_q       <= '0;
      usb_q        <= 1'b0;
      msg_q        <= '0;
      req_ready_q  <= '0;
      eng_start_q  <= 1'b0;
      eng_role_q   <= 1'b0;
      eng_msg_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_msg_q   <= '0;
      resp_chan_q  <= '0;
      err_valid_q  <= 1'b0;
      err_code_q   <= '0;
      busy_q       <= 1'b0;
`ifdef AUTH_DRV_TIMEOUT_EN
      to_cnt_q     <= '0;
      retry_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      chan_q       <= chan_d;
      role_q       <= role_d;
      usb_q        <= usb_d;
      msg_q        <= msg_d;
      req_ready_q  <= req_ready_d;
      eng_start_q  <= eng_start_d;
      eng_role_q   <= eng_role_d;
      eng_msg_q    <= eng_msg_d;
      resp_valid_q <= resp_valid_d;
      resp_msg_q   <= resp_msg_d;
      resp_chan_q  <= resp_chan_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
      busy_q       <= busy_d;
`ifdef AUTH_DRV_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      retry_q      <= retry_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign eng_start  = eng_start_q;
  assign eng_role   = eng_role_q;
  assign eng_msg    = eng_msg_q;
  assign resp_valid = resp_valid_q;
  assign resp_msg   = resp_msg_q;
  assign resp_chan  = resp_chan_q;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_auth_driver_mc.sv
// Directed bench for auth_driver_mc: grant, round-robin, role errors, USB framing,
// ack wait (timeout/retry when AUTH_DRV_TIMEOUT_EN is defined) and mid-transaction reset.
module tb_auth_driver_mc;
  localparam int NUM_REQ     = 2;
  localparam int MSG_W       = 64;
  localparam int ACK_TIMEOUT = 4;
  localparam int MAX_RETRY   = 1;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [8*NUM_REQ-1:0]     req_cmd;
  logic [MSG_W*NUM_REQ-1:0] req_msg;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     eng_start;
  logic                     eng_role;
  logic [MSG_W-1:0]         eng_msg;
  logic                     eng_done;
  logic [MSG_W-1:0]         eng_resp;
  logic                     resp_valid;
  logic [MSG_W-1:0]         resp_msg;
  logic [0:0]               resp_chan;
  logic                     ack_in;
  logic                     err_valid;
  logic [1:0]               err_code;
  logic                     busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  auth_driver_mc #(
    .NUM_REQ(NUM_REQ), .MSG_W(MSG_W), .ACK_TIMEOUT(ACK_TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_cmd(req_cmd), .req_msg(req_msg),
    .req_ready(req_ready), .eng_start(eng_start), .eng_role(eng_role), .eng_msg(eng_msg),
    .eng_done(eng_done), .eng_resp(eng_resp), .resp_valid(resp_valid), .resp_msg(resp_msg),
    .resp_chan(resp_chan), .ack_in(ack_in), .err_valid(err_valid), .err_code(err_code),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; req_cmd = '0; req_msg = '0;
    eng_done = 1'b0; eng_resp = '0; ack_in = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b expected 00", req_ready); end
    checks++; if ({eng_start, resp_valid, err_valid, err_code} !== 5'b0) begin errors++; $display("FAIL rst_ctrl: got %b expected 00000", {eng_start, resp_valid, err_valid, err_code}); end
    reset = 1'b0;
    // Stray engine done / ack while idle must do nothing.
    eng_done = 1'b1; eng_resp = 64'h55; ack_in = 1'b1;
    tick();
    eng_done = 1'b0; ack_in = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_ignore_busy: got %b expected 0", busy); end
    checks++; if (resp_msg !== 64'h0) begin errors++; $display("FAIL idle_ignore_msg: got %h expected 0", resp_msg); end
    $display("txn reset: outputs idle");
  endtask

  task automatic test_basic();
    req_cmd = {8'h00, 8'h10}; req_msg = {64'h0, 64'h1234}; req_valid = 2'b01;
    tick();
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL basic_ready: got %b expected 01", req_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
    req_valid = 2'b00;
    tick();
    checks++; if ({eng_start, eng_role} !== 2'b10) begin errors++; $display("FAIL basic_start: got %b expected 10", {eng_start, eng_role}); end
    checks++; if (eng_msg !== 64'h1234) begin errors++; $display("FAIL basic_eng_msg: got %h expected 1234", eng_msg); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL basic_ready_drop: got %b expected 00", req_ready); end
    tick();
    checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL basic_start_pulse: got %b expected 0", eng_start); end
    tick();
    eng_done = 1'b1; eng_resp = 64'hBEEF;
    tick();
    eng_done = 1'b0;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL basic_resp_valid: got %b expected 1", resp_valid); end
    checks++; if (resp_msg !== 64'hBEEF) begin errors++; $display("FAIL basic_resp_msg: got %h expected beef", resp_msg); end
    checks++; if (resp_chan !== 1'b0) begin errors++; $display("FAIL basic_resp_chan: got %b expected 0", resp_chan); end
    tick(); tick();
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL basic_resp_hold: got %b expected 1", resp_valid); end
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    checks++; if ({resp_valid, busy} !== 2'b00) begin errors++; $display("FAIL basic_ack: got %b expected 00", {resp_valid, busy}); end
    $display("txn basic: ch=0 resp=%h", resp_msg);
  endtask

  task automatic test_round_robin();
    reset = 1'b1; tick(); reset = 1'b0;
    req_cmd = {8'h10, 8'h10}; req_msg = {64'hB1, 64'hA0}; req_valid = 2'b11;
    tick();
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_first: got %b expected 01", req_ready); end
    req_valid = 2'b10;
    tick();
    checks++; if (eng_msg !== 64'hA0) begin errors++; $display("FAIL rr_first_msg: got %h expected a0", eng_msg); end
    eng_done = 1'b1; eng_resp = 64'h1;
    tick();
    eng_done = 1'b0; ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    $display("txn rr: ch=0 done");
    tick();
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rr_second: got %b expected 10", req_ready); end
    req_valid = 2'b00;
    tick();
    checks++; if (eng_msg !== 64'hB1) begin errors++; $display("FAIL rr_second_msg: got %h expected b1", eng_msg); end
    eng_done = 1'b1; eng_resp = 64'h2;
    tick();
    eng_done = 1'b0;
    checks++; if (resp_chan !== 1'b1) begin errors++; $display("FAIL rr_second_chan: got %b expected 1", resp_chan); end
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    $display("txn rr: ch=1 done");
  endtask

  task automatic test_invalid_role();
    req_cmd = {8'h30, 8'h10}; req_valid = 2'b10;
    tick();
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL inv11_ready: got %b expected 10", req_ready); end
    req_valid = 2'b00;
    tick();
    checks++; if ({err_valid, err_code, eng_start} !== 4'b1010) begin errors++; $display("FAIL inv11_err: got %b expected 1010", {err_valid, err_code, eng_start}); end
    tick();
    checks++; if ({err_valid, err_code, busy} !== 4'b0010) begin errors++; $display("FAIL inv11_idle: got %b expected 0010", {err_valid, err_code, busy}); end
    $display("txn invalid role 11: ch=1 err_code=%b", err_code);
    req_cmd = {8'h10, 8'h00}; req_valid = 2'b01;
    tick();
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL inv00_ready: got %b expected 01", req_ready); end
    req_valid = 2'b00;
    tick();
    checks++; if ({err_valid, eng_start} !== 2'b10) begin errors++; $display("FAIL inv00_err: got %b expected 10", {err_valid, eng_start}); end
    tick();
    $display("txn invalid role 00: ch=0 err_code=%b", err_code);
  endtask

  task automatic test_usb_frame();
    req_cmd = {8'h10, 8'h24}; req_msg = {64'h0, 64'hCAFE}; req_valid = 2'b01;
    tick();
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL usb_ready: got %b expected 01", req_ready); end
    req_valid = 2'b00;
    tick();
    checks++; if ({eng_start, eng_role} !== 2'b11) begin errors++; $display("FAIL usb_start: got %b expected 11", {eng_start, eng_role}); end
    eng_done = 1'b1; eng_resp = {MSG_W{1'b1}};
    tick();
    eng_done = 1'b0;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL usb_frame_cycle: got %b expected 0", resp_valid); end
    tick();
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL usb_valid: got %b expected 1", resp_valid); end
    checks++; if (resp_msg !== 64'h5AFFFFFFFFFFFFFF) begin errors++; $display("FAIL usb_msg: got %h expected 5affffffffffffff", resp_msg); end
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    checks++; if ({resp_valid, busy} !== 2'b00) begin errors++; $display("FAIL usb_ack: got %b expected 00", {resp_valid, busy}); end
    $display("txn usb: ch=0 resp=%h", resp_msg);
  endtask

  task automatic test_ack_wait();
    req_cmd = {8'h10, 8'h10}; req_valid = 2'b10;
    tick();
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL wait_ready: got %b expected 10", req_ready); end
    req_valid = 2'b00;
    tick();
    eng_done = 1'b1; eng_resp = 64'hC0DE;
    tick();
    eng_done = 1'b0;
`ifdef AUTH_DRV_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL to_first_window[%0d]: got %b expected 1", i, resp_valid); end
      tick();
    end
    checks++; if ({resp_valid, busy} !== 2'b01) begin errors++; $display("FAIL to_retry_gap: got %b expected 01", {resp_valid, busy}); end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL to_second_window[%0d]: got %b expected 1", i, resp_valid); end
      tick();
    end
    checks++; if ({err_valid, err_code, resp_valid} !== 4'b1100) begin errors++; $display("FAIL to_error: got %b expected 1100", {err_valid, err_code, resp_valid}); end
    tick();
    checks++; if ({err_valid, busy} !== 2'b00) begin errors++; $display("FAIL to_error_idle: got %b expected 00", {err_valid, busy}); end
    $display("txn timeout: ch=1 err_code=%b", err_code);
    // Ack in the very cycle the timeout would fire.
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    eng_done = 1'b1; eng_resp = 64'hD00D;
    tick();
    eng_done = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL to_ack_race_pre: got %b expected 1", resp_valid); end
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    checks++; if ({resp_valid, err_valid, busy} !== 3'b000) begin errors++; $display("FAIL to_ack_race: got %b expected 000", {resp_valid, err_valid, busy}); end
    tick();
    checks++; if ({err_valid, busy} !== 2'b00) begin errors++; $display("FAIL to_ack_race_after: got %b expected 00", {err_valid, busy}); end
    $display("txn ack on timeout cycle: ch=0 clean");
`else
    for (int i = 0; i < 20; i++) begin
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL wait_hold[%0d]: got %b expected 1", i, resp_valid); end
      tick();
    end
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    checks++; if ({resp_valid, err_valid, busy} !== 3'b000) begin errors++; $display("FAIL wait_ack: got %b expected 000", {resp_valid, err_valid, busy}); end
    $display("txn long wait: ch=1 resp=%h", resp_msg);
`endif
  endtask

  task automatic test_reset_mid();
    req_cmd = {8'h10, 8'h10}; req_msg = {64'h0, 64'h77}; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    checks++; if (eng_start !== 1'b1) begin errors++; $display("FAIL mid_start: got %b expected 1", eng_start); end
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (eng_msg !== 64'h0) begin errors++; $display("FAIL mid_eng_msg: got %h expected 0", eng_msg); end
    checks++; if ({req_ready, eng_start, eng_role, resp_valid, err_valid, err_code} !== 8'b0) begin errors++; $display("FAIL mid_outputs: got %b expected 00000000", {req_ready, eng_start, eng_role, resp_valid, err_valid, err_code}); end
    reset = 1'b0;
    eng_done = 1'b1; eng_resp = 64'h99;
    tick();
    eng_done = 1'b0;
    checks++; if ({resp_valid, busy} !== 2'b00) begin errors++; $display("FAIL mid_late_done: got %b expected 00", {resp_valid, busy}); end
    checks++; if (resp_msg !== 64'h0) begin errors++; $display("FAIL mid_late_msg: got %h expected 0", resp_msg); end
    tick();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_late_after: got %b expected 0", resp_valid); end
    $display("txn reset mid-engine: idle");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_invalid_role();
    test_usb_frame();
    test_ack_wait();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/auth_driver_mc.md
AUTH_DRIVER_MC -- requirements
Module: auth_driver_mc

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requester channels (2..8); channel 0 = PD, channel 1 = DEBUG.
REQ-002 Parameter MSG_W, default 64: authentication message width in bits (>=16).
REQ-003 Parameter ACK_TIMEOUT, default 255: cycles to wait in WAIT_ACK before a timeout (>=1).
REQ-004 Parameter MAX_RETRY, default 3: re-presentations allowed after timeouts (0..15).
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 req_valid  in  NUM_REQ  per-channel pending request; held until the matching req_ready.
REQ-009 req_cmd  in  8*NUM_REQ  per-channel descriptor; [5:4] role (01 responder, 10 initiator), [2] USB framing.
REQ-010 req_msg  in  MSG_W*NUM_REQ  per-channel request message.
REQ-011 req_ready  out  NUM_REQ  one-hot, one-cycle grant/capture pulse.
REQ-012 eng_start  out  1  one-cycle start pulse to the authentication engine.
REQ-013 eng_role  out  1  0 = responder, 1 = initiator; stable from eng_start until eng_done.
REQ-014 eng_msg  out  MSG_W  captured request message; stable from eng_start until eng_done.
REQ-015 eng_done  in  1  engine completion strobe; eng_resp valid in the same cycle.
REQ-016 eng_resp  in  MSG_W  engine response.
REQ-017 resp_valid  out  1  response presented to the link.
REQ-018 resp_msg  out  MSG_W  response payload.
REQ-019 resp_chan  out  max(1,$clog2(NUM_REQ))  channel that owns the response.
REQ-020 ack_in  in  1  link acknowledge.
REQ-021 err_valid  out  1  one-cycle error pulse.
REQ-022 err_code  out  2  01 invalid role, 10 ack timeout; held until the next error.
REQ-023 busy  out  1  high in every state except IDLE.

Function
REQ-024 The FSM SHALL have states IDLE, DISPATCH, ENGINE, FRAME, WAIT_ACK, RETRY, ERROR; all outputs are registered.
REQ-025 In IDLE, when any req_valid is high, the block SHALL pick channel g round-robin starting at pointer rr, capture req_cmd[g] and req_msg[g] at that edge, go to DISPATCH, and assert req_ready[g] for exactly that DISPATCH cycle.
REQ-026 In DISPATCH, if the role is 01 or 10, the block SHALL pulse eng_start, drive eng_role and eng_msg, and go to ENGINE.
REQ-027 In DISPATCH, if the role is 00 or 11, the block SHALL go to ERROR with err_code 01; the engine is not started.
REQ-028 In ENGINE, on eng_done the block SHALL capture eng_resp and go to FRAME if USB=1, otherwise to WAIT_ACK.
REQ-029 In FRAME (one cycle), the block SHALL replace resp_msg[MSG_W-1:MSG_W-8] with 8'h5A and go to WAIT_ACK.
REQ-030 In WAIT_ACK, resp_valid, resp_msg and resp_chan SHALL be held; on ack_in the block SHALL return to IDLE, drop resp_valid, and set rr to (g+1) mod NUM_REQ.
REQ-031 If ack_in and a timeout occur in the same cycle, ack_in SHALL win.
REQ-032 ERROR SHALL last one cycle, pulse err_valid, set rr to (g+1) mod NUM_REQ, and return to IDLE.
REQ-033 eng_done outside ENGINE and ack_in outside WAIT_ACK SHALL be ignored.
REQ-034 The rr pointer SHALL wrap from NUM_REQ-1 to 0; a requester that is not granted keeps its request pending.

Reset
REQ-035 While reset is high, the block SHALL go to IDLE, set rr, the timeout counter and the retry counter to 0, and drive every output to 0, including mid-transaction.

Configuration
REQ-036 With AUTH_DRV_TIMEOUT_EN defined, the timeout counter SHALL count cycles in WAIT_ACK; on reaching ACK_TIMEOUT:
- if retries < MAX_RETRY: go to RETRY (resp_valid low for one cycle), increment retries, clear the counter, and re-enter WAIT_ACK;
- otherwise: go to ERROR with err_code 10.
REQ-037 Without AUTH_DRV_TIMEOUT_EN, WAIT_ACK SHALL wait indefinitely; RETRY and err_code 10 are unreachable and the counters are not built.

Verification
REQ-038 req_valid=01, cmd role=01, USB=0, msg=0x1234; eng_done after 3 cycles with resp=0xBEEF -> req_ready=01 pulse, eng_start pulse with role=0, resp_valid with 0xBEEF and chan 0 until ack_in.
REQ-039 req_valid=11, both valid, twice in sequence -> first grant channel 0, second grant channel 1 (round-robin).
REQ-040 role=11 on channel 1 -> req_ready=10, no eng_start, err_valid pulse with err_code=01, back to IDLE.
REQ-041 USB=1, resp=0xFFFF...FF, MSG_W=64 -> resp_msg=0x5AFFFFFFFFFFFFFF.
REQ-042 TIMEOUT_EN, ACK_TIMEOUT=4, MAX_RETRY=1, no ack -> resp_valid high for 4 cycles, low 1, high 4, then err_valid with err_code=10; ack_in arriving in the timeout cycle -> clean completion, no error.
REQ-043 reset asserted during ENGINE -> next cycle busy=0, all outputs 0; a later eng_done is ignored.
